// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder measurement sequencer.
//   - cmd_op_t    : command opcodes carried on cmd_op
//   - seq_state_t : sequencer FSM states, also visible on dbg_state
//   - WINDOW_W    : width of the measurement window length field
package adder_seq_pkg;

  localparam int WINDOW_W = 16;

  typedef enum logic [1:0] {
    OP_LOAD_A = 2'd0,
    OP_LOAD_B = 2'd1,
    OP_RUN    = 2'd2,
    OP_CLEAR  = 2'd3
  } cmd_op_t;

  // Gray-style encoding: bit 0 is set exactly in SETTLE and MEASURE, so
  // the ring enable is a single flop output and cannot glitch on any
  // state transition (including SETTLE -> REPORT).
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    MEASURE = 2'b11,
    REPORT  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/ring_edge_counter.sv
// Synchronises the divided ring-oscillator output into the system clock
// domain, detects rising edges and counts them with saturation.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ring_div     divided ring output (asynchronous to clk)
//   clear        forces the count to zero (takes priority over counting)
//   count_en     allows detected edges to be counted
//   count_now    count including any edge detected in the current cycle;
//                this is the value the count register takes at the next edge
module ring_edge_counter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring_div,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count_now
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       count_q;
  logic                   rise;

  // The synchroniser and edge-detect flop run continuously; the owner of
  // count_en is expected to give them at least one cycle of history
  // before enabling the count.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    count_now = count_q;
    if (clear) begin
      count_now = '0;
    end else if (count_en && rise && (count_q != {CNT_W{1'b1}})) begin
      count_now = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ring_div};
      prev_q  <= sync_q[SYNC_STAGES-1];
      count_q <= count_now;
    end
  end

endmodule

// File: rtl/adder_measure_sequencer.sv
// Control stage in front of the instrumented Sklansky adder. Accepts
// operand/run commands, drives the adder operands, gates the ring
// oscillator for a programmable window, counts divided ring edges and
// returns the captured sum and edge count on a result port.
// Ports:
//   wb_clk_i, wb_rst_n     system clock, asynchronous active-low reset
//   cmd_valid/ready/op/data command port (LOAD_A, LOAD_B, RUN, CLEAR)
//   a_input, b_input       operands to the adder
//   ring_en                ring oscillator enable
//   sum_i                  adder sum
//   ring_div_i             divided ring output (asynchronous)
//   res_valid/ready        result handshake
//   res_sum, res_count     captured sum and ring edge count
//   busy                   high whenever the FSM is not IDLE
//   dbg_state              current FSM state
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The sender holds valid and its payload until that
// edge; ready never depends combinationally on valid. Both ready and
// res_valid are decoded from registered state only.
module adder_measure_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 24,
  parameter int SETTLE_CYC  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] a_input,
  output logic [WIDTH-1:0] b_input,
  output logic             ring_en,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             ring_div_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic [CNT_W-1:0] res_count,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Settle counter counts 0 .. SETTLE_CYC-1.
  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  seq_state_t          state;
  seq_state_t          next_state;
  cmd_op_t             op;
  logic [WINDOW_W-1:0] window_q;
  logic [WINDOW_W-1:0] win_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic                out_of_reset;
  logic                cmd_fire;
  logic                settle_last;
  logic                measure_last;
  logic                window_zero;
  logic                capture;
  logic [CNT_W-1:0]    count_now;

  assign op           = cmd_op_t'(cmd_op);
  assign cmd_fire     = cmd_valid & cmd_ready;
  assign window_zero  = (window_q == '0);
  assign settle_last  = (settle_cnt == SET_W'(SETTLE_CYC - 1));
  assign measure_last = (win_cnt == (window_q - WINDOW_W'(1)));

  // Result registers load on the final cycle of the ring-enabled phase:
  // the last MEASURE cycle, or the last SETTLE cycle when the window is 0.
  assign capture = ((state == SETTLE) && settle_last && window_zero) ||
                   ((state == MEASURE) && measure_last);

  // cmd_ready is held low while in reset and rises at the first edge after
  // release, so every output reads 0 during reset.
  assign cmd_ready = out_of_reset & (state == IDLE);
  assign ring_en   = state[0];
  assign res_valid = (state == REPORT);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_fire && (op == OP_RUN)) next_state = SETTLE;
      end
      SETTLE: begin
        if (settle_last) next_state = window_zero ? REPORT : MEASURE;
      end
      MEASURE: begin
        if (measure_last) next_state = REPORT;
      end
      REPORT: begin
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
      window_q     <= '0;
      win_cnt      <= '0;
      settle_cnt   <= '0;
      a_input      <= '0;
      b_input      <= '0;
      res_sum      <= '0;
      res_count    <= '0;
    end else begin
      state        <= next_state;
      out_of_reset <= 1'b1;

      // Phase counters restart from zero every time their state is entered.
      settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;
      win_cnt    <= (state == MEASURE) ? win_cnt + WINDOW_W'(1) : '0;

      // cmd_fire is only possible in IDLE, so operands never move mid-run.
      if (cmd_fire) begin
        case (op)
          OP_LOAD_A: a_input  <= cmd_data;
          OP_LOAD_B: b_input  <= cmd_data;
          OP_RUN:    window_q <= cmd_data[WINDOW_W-1:0];
          OP_CLEAR: begin
            a_input   <= '0;
            b_input   <= '0;
            res_sum   <= '0;
            res_count <= '0;
          end
          default: ;
        endcase
      end

      if (capture) begin
        res_sum   <= sum_i;
        res_count <= (state == SETTLE) ? '0 : count_now;
      end
    end
  end

  // Counter is held clear for all of SETTLE, which also lets the
  // edge-detect history flush before counting starts.
  ring_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ring_edge_counter (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n),
    .ring_div  (ring_div_i),
    .clear     (state == SETTLE),
    .count_en  (state == MEASURE),
    .count_now (count_now)
  );

endmodule

// File: tb/tb_adder_measure_sequencer.sv
module tb_adder_measure_sequencer;
  import adder_seq_pkg::*;

  // ---------------- clock / reset / shared stimulus ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = '0;
  logic        res_ready = 1'b0;
  logic        ring_div = 1'b0;
  logic        ring_run = 1'b0;
  logic [1:0]  ring_ph = 2'd0;

  always #5 clk = ~clk;

  // Ring model: toggles every 4 clocks while ring_run is set.
  always @(posedge clk) begin
    if (ring_run) begin
      if (ring_ph == 2'd3) begin
        ring_ph  <= 2'd0;
        ring_div <= ~ring_div;
      end else begin
        ring_ph <= ring_ph + 2'd1;
      end
    end
  end

  // ---------------- main DUT (CNT_W = 24) ----------------
  logic        cmd_valid_m = 1'b0;
  logic        cmd_ready_m, ring_en_m, res_valid_m, busy_m;
  logic [31:0] a_m, b_m, sum_m, res_sum_m;
  logic [23:0] res_count_m;
  logic [1:0]  dbg_m;
  assign sum_m = a_m + b_m;

  adder_measure_sequencer #(.WIDTH(32), .CNT_W(24), .SETTLE_CYC(2), .SYNC_STAGES(2)) u_dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .cmd_valid(cmd_valid_m), .cmd_ready(cmd_ready_m), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .a_input(a_m), .b_input(b_m), .ring_en(ring_en_m), .sum_i(sum_m), .ring_div_i(ring_div),
    .res_valid(res_valid_m), .res_ready(res_ready), .res_sum(res_sum_m), .res_count(res_count_m),
    .busy(busy_m), .dbg_state(dbg_m)
  );

  // ---------------- saturation DUT (CNT_W = 4) ----------------
  logic        cmd_valid_s = 1'b0;
  logic        cmd_ready_s, ring_en_s, res_valid_s, busy_s;
  logic [31:0] a_s, b_s, sum_s, res_sum_s;
  logic [3:0]  res_count_s;
  logic [1:0]  dbg_s;
  assign sum_s = a_s + b_s;

  adder_measure_sequencer #(.WIDTH(32), .CNT_W(4), .SETTLE_CYC(2), .SYNC_STAGES(2)) u_sat (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .a_input(a_s), .b_input(b_s), .ring_en(ring_en_s), .sum_i(sum_s), .ring_div_i(ring_div),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_sum(res_sum_s), .res_count(res_count_s),
    .busy(busy_s), .dbg_state(dbg_s)
  );

  // ---------------- scoreboard counters ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input bit sat, input logic [1:0] op, input logic [31:0] data);
    int n;
    n = 0;
    cmd_op   = op;
    cmd_data = data;
    if (sat) cmd_valid_s = 1'b1; else cmd_valid_m = 1'b1;
    while (!(sat ? cmd_ready_s : cmd_ready_m) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (n >= 200) $display("FAIL cmd_accept_timeout: waited %0d cycles, required < 200", n);
    else pass_cnt++;
    @(posedge clk); #1;
    cmd_valid_m = 1'b0;
    cmd_valid_s = 1'b0;
  endtask

  // Called right after the RUN handshake. lat counts the handshake cycle
  // as cycle 0, so the first post-handshake cycle is 1.
  task automatic wait_result(input bit sat, output int lat, output int ring_hi);
    lat = 1;
    ring_hi = 0;
    while (!(sat ? res_valid_s : res_valid_m) && lat < 1000) begin
      if (sat ? ring_en_s : ring_en_m) ring_hi++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({cmd_ready_m, ring_en_m, res_valid_m, busy_m} !== 4'b0000) $display("FAIL reset_ctrl: got %b required 0000", {cmd_ready_m, ring_en_m, res_valid_m, busy_m});
    else pass_cnt++;
    total_cnt++;
    if ({a_m, b_m, res_sum_m} !== 96'd0) $display("FAIL reset_data: a=%h b=%h sum=%h required all 0", a_m, b_m, res_sum_m);
    else pass_cnt++;
    total_cnt++;
    if ({res_count_m, dbg_m} !== 26'd0) $display("FAIL reset_count: count=%0d state=%0d required 0", res_count_m, dbg_m);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (cmd_ready_m !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", cmd_ready_m);
    else pass_cnt++;
  endtask

  task automatic test_basic_run();
    int lat, hi;
    logic cnt_ok;
    ring_run = 1'b1;
    send_cmd(1'b0, OP_LOAD_A, 32'h0000_0005);
    send_cmd(1'b0, OP_LOAD_B, 32'h0000_0003);
    total_cnt++;
    if ({a_m, b_m} !== {32'd5, 32'd3}) $display("FAIL load_operands: a=%h b=%h required 5 3", a_m, b_m);
    else pass_cnt++;
    send_cmd(1'b0, OP_RUN, 32'd8);
    wait_result(1'b0, lat, hi);
    total_cnt++;
    if (lat !== 11) $display("FAIL run8_latency: got %0d required 11", lat);
    else pass_cnt++;
    total_cnt++;
    if (hi !== 10) $display("FAIL run8_ring_en_cycles: got %0d required 10", hi);
    else pass_cnt++;
    total_cnt++;
    if (res_sum_m !== 32'd8) $display("FAIL run8_sum: got %0d required 8", res_sum_m);
    else pass_cnt++;
    cnt_ok = (res_count_m == 24'd1) || (res_count_m == 24'd2);
    total_cnt++;
    if (!cnt_ok) $display("FAIL run8_count: got %0d required 1 or 2", res_count_m);
    else pass_cnt++;
    total_cnt++;
    if ({ring_en_m, busy_m, cmd_ready_m, dbg_m} !== 5'b01010) $display("FAIL report_flags: ring_en/busy/ready/state=%b required 01010", {ring_en_m, busy_m, cmd_ready_m, dbg_m});
    else pass_cnt++;
    pop_result();
    total_cnt++;
    if ({res_valid_m, busy_m} !== 2'b00) $display("FAIL run8_pop: valid/busy=%b required 00", {res_valid_m, busy_m});
    else pass_cnt++;
  endtask

  task automatic test_window_zero();
    int lat, hi;
    res_ready = 1'b1;
    send_cmd(1'b0, OP_RUN, 32'd0);
    wait_result(1'b0, lat, hi);
    total_cnt++;
    if (lat !== 3) $display("FAIL win0_latency: got %0d required 3", lat);
    else pass_cnt++;
    total_cnt++;
    if (hi !== 2) $display("FAIL win0_ring_en_cycles: got %0d required 2", hi);
    else pass_cnt++;
    total_cnt++;
    if ({res_count_m, res_sum_m} !== {24'd0, 32'd8}) $display("FAIL win0_result: count=%0d sum=%0d required 0 8", res_count_m, res_sum_m);
    else pass_cnt++;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total_cnt++;
    if ({res_valid_m, cmd_ready_m} !== 2'b01) $display("FAIL win0_one_cycle_report: valid/ready=%b required 01", {res_valid_m, cmd_ready_m});
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int lat, hi;
    ring_run = 1'b1;
    send_cmd(1'b1, OP_RUN, 32'd200);
    total_cnt++;
    if (busy_s !== 1'b1) $display("FAIL sat_busy: got %b required 1", busy_s);
    else pass_cnt++;
    wait_result(1'b1, lat, hi);
    total_cnt++;
    if (lat !== 203) $display("FAIL sat_latency: got %0d required 203", lat);
    else pass_cnt++;
    total_cnt++;
    if ({res_count_s, dbg_s} !== {4'd15, 2'b10}) $display("FAIL sat_count: count=%0d state=%0d required 15 2", res_count_s, dbg_s);
    else pass_cnt++;
    pop_result();
  endtask

  task automatic test_report_stall();
    int lat, hi;
    ring_run = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send_cmd(1'b0, OP_RUN, 32'd3);
    wait_result(1'b0, lat, hi);
    total_cnt++;
    if (lat !== 6) $display("FAIL stall_latency: got %0d required 6", lat);
    else pass_cnt++;
    cmd_op = OP_LOAD_A;
    cmd_data = 32'h0000_0055;
    cmd_valid_m = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({res_valid_m, cmd_ready_m, res_sum_m, res_count_m, a_m} !== {1'b1, 1'b0, 32'd8, 24'd0, 32'd5})
        $display("FAIL stall_hold[%0d]: valid=%b ready=%b sum=%0d count=%0d a=%h required 1 0 8 0 5",
                 i, res_valid_m, cmd_ready_m, res_sum_m, res_count_m, a_m);
      else pass_cnt++;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total_cnt++;
    if ({res_valid_m, cmd_ready_m, a_m} !== {1'b0, 1'b1, 32'd5}) $display("FAIL stall_release: valid=%b ready=%b a=%h required 0 1 5", res_valid_m, cmd_ready_m, a_m);
    else pass_cnt++;
    @(posedge clk); #1;
    cmd_valid_m = 1'b0;
    total_cnt++;
    if (a_m !== 32'h55) $display("FAIL stall_load_after_idle: a=%h required 55", a_m);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    ring_run = 1'b1;
    send_cmd(1'b0, OP_LOAD_A, 32'h0000_0005);
    send_cmd(1'b0, OP_RUN, 32'd50);
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if ({ring_en_m, busy_m, dbg_m} !== 4'b1111) $display("FAIL mid_measure: ring_en/busy/state=%b required 1111", {ring_en_m, busy_m, dbg_m});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({ring_en_m, busy_m, res_valid_m, a_m} !== 35'd0) $display("FAIL async_abort: ring_en=%b busy=%b valid=%b a=%h required all 0", ring_en_m, busy_m, res_valid_m, a_m);
    else pass_cnt++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({cmd_ready_m, busy_m} !== 2'b10) $display("FAIL abort_release: ready/busy=%b required 10", {cmd_ready_m, busy_m});
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int lat, hi;
    ring_run = 1'b1;
    send_cmd(1'b0, OP_LOAD_A, 32'h0000_0005);
    send_cmd(1'b0, OP_LOAD_B, 32'h0000_0003);
    send_cmd(1'b0, OP_RUN, 32'd16);
    wait_result(1'b0, lat, hi);
    total_cnt++;
    if (res_sum_m !== 32'd8) $display("FAIL pre_clear_sum: got %0d required 8", res_sum_m);
    else pass_cnt++;
    pop_result();
    send_cmd(1'b0, OP_CLEAR, 32'hFFFF_FFFF);
    total_cnt++;
    if ({a_m, b_m, res_sum_m, res_count_m} !== 120'd0) $display("FAIL clear: a=%h b=%h sum=%h count=%0d required all 0", a_m, b_m, res_sum_m, res_count_m);
    else pass_cnt++;
    ring_run = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_cmd(1'b0, OP_RUN, 32'd6);
    wait_result(1'b0, lat, hi);
    total_cnt++;
    if (lat !== 9) $display("FAIL idle_ring_latency: got %0d required 9", lat);
    else pass_cnt++;
    total_cnt++;
    if ({res_count_m, res_sum_m} !== 56'd0) $display("FAIL idle_ring_result: count=%0d sum=%0d required 0 0", res_count_m, res_sum_m);
    else pass_cnt++;
    pop_result();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_run();
    test_window_zero();
    test_saturate();
    test_report_stall();
    test_reset_mid_run();
    test_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
